bit_scan: RTL and testbench

Streaming set-bit scanner for the sieve datapath. Accepts one WIDTH-bit bitmap word plus its base index, and emits the absolute index of every set bit, highest bit first, one per cycle over a valid/ready stream. It instantiates `prio_enc` on its working bitmap and consumes the `msb` result each cycle. It sits between the sieve bitmap reader (upstream) and the prime output/accumulation logic (downstream).

---
 rtl/bit_scan.sv | 146 ++++++++++++++
 tb/tb_bit_scan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan.sv
// bit_scan: streaming set-bit scanner.
// Takes a WIDTH-bit bitmap word with its base index and emits the absolute index of each set
// bit, highest first, one per cycle over a valid/ready stream.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   in_valid   in   upstream word available
//   in_ready   out  a word can be accepted this cycle (0 while rst is high)
//   in_data    in   WIDTH-bit bitmap word
//   in_base    in   absolute index of bit 0 of in_data
//   out_valid  out  out_idx is valid
//   out_ready  in   downstream accepts out_idx
//   out_idx    out  base + index of the current highest set bit (mod 2^16)
//   out_last   out  current index is the last set bit of its word
//
// prio_enc: index of the highest set bit of in_bits (0 when in_bits is 0).
//   in_bits    in   2**WIDTH_LOG-bit vector
//   msb        out  8-bit bit index

module prio_enc #(
    parameter int unsigned WIDTH_LOG = 4
) (
    input  logic [(1 << WIDTH_LOG)-1:0] in_bits,
    output logic [7:0]                  msb
);

    always_comb begin
        msb = 8'd0;
        // Later (higher) hits overwrite earlier ones, leaving the MSB.
        for (int i = 0; i < (1 << WIDTH_LOG); i++) begin
            if (in_bits[i]) begin
                msb = 8'(i);
            end
        end
    end

endmodule

module bit_scan #(
    parameter int unsigned WIDTH_LOG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(1 << WIDTH_LOG)-1:0] in_data,
    input  logic [15:0]                 in_base,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 out_idx,
    output logic                        out_last
);

    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    typedef enum logic {StIdle, StScan} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [WIDTH-1:0]  r_bits;
    logic [WIDTH-1:0]  w_bits_d;
    logic [15:0]       r_base;
    logic [15:0]       w_base_d;

    logic [7:0]        w_msb;
    logic [WIDTH-1:0]  w_clear;
    logic [WIDTH-1:0]  w_rest;
    logic              w_rest_zero;
    logic              w_in_nz;
    logic              w_accept;

    prio_enc #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_prio_enc (
        .in_bits (r_bits),
        .msb     (w_msb)
    );

    // Working bitmap with the bit being emitted this cycle removed.
    assign w_clear     = WIDTH'(1) << w_msb;
    assign w_rest      = r_bits & ~w_clear;
    assign w_rest_zero = (w_rest == '0);
    assign w_in_nz     = |in_data;
    assign w_accept    = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_bits  <= '0;
            r_base  <= 16'd0;
        end else begin
            r_state <= w_state_d;
            r_bits  <= w_bits_d;
            r_base  <= w_base_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_bits_d  = r_bits;
        w_base_d  = r_base;
        unique case (r_state)
            StIdle: begin
                // A zero word is consumed here with no output.
                if (w_accept && w_in_nz) begin
                    w_state_d = StScan;
                    w_bits_d  = in_data;
                    w_base_d  = in_base;
                end
            end
            StScan: begin
                if (out_ready) begin
                    if (!w_rest_zero) begin
                        w_bits_d = w_rest;
                    end else if (w_accept && w_in_nz) begin
                        // Back-to-back load: next word's first index follows with no bubble.
                        w_bits_d = in_data;
                        w_base_d = in_base;
                    end else begin
                        w_state_d = StIdle;
                        w_bits_d  = '0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = (r_state == StScan);
        in_ready  = !rst && ((r_state == StIdle) || (out_ready && w_rest_zero));
        out_idx   = 16'd0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_idx  = r_base + {8'd0, w_msb};
            out_last = w_rest_zero;
        end
    end

endmodule

// File: tb/tb_bit_scan.sv
// tb_bit_scan: directed bench for bit_scan at WIDTH_LOG = 4, 1 and 6.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.

module tb_bit_scan;

    logic        clk;
    logic        rst;
    logic        out_ready;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_base;
    logic        out_valid;
    logic [15:0] out_idx;
    logic        out_last;

    logic        in_valid1;
    logic        in_ready1;
    logic [1:0]  in_data1;
    logic [15:0] in_base1;
    logic        out_valid1;
    logic [15:0] out_idx1;
    logic        out_last1;

    logic        in_valid6;
    logic        in_ready6;
    logic [63:0] in_data6;
    logic [15:0] in_base6;
    logic        out_valid6;
    logic [15:0] out_idx6;
    logic        out_last6;

    int n_cmp;
    int n_fail;

    bit_scan #(.WIDTH_LOG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    bit_scan #(.WIDTH_LOG(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .in_base   (in_base1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_idx   (out_idx1),
        .out_last  (out_last1)
    );

    bit_scan #(.WIDTH_LOG(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .in_data   (in_data6),
        .in_base   (in_base6),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .out_idx   (out_idx6),
        .out_last  (out_last6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 units after the next rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic check_main(input string tag, input logic v, input logic [15:0] idx,
                              input logic last, input logic rdy);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check({tag, ".out_idx"},   64'(out_idx),   64'(idx));
        check({tag, ".out_last"},  64'(out_last),  64'(last));
        check({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
    endtask

    initial begin
        logic [15:0] exp_idx;
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0; in_data  = '0; in_base  = '0;
        in_valid1 = 1'b0; in_data1 = '0; in_base1 = '0;
        in_valid6 = 1'b0; in_data6 = '0; in_base6 = '0;

        // Reset state
        next_cycle();
        #1;
        check_main("reset", 1'b0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_main("post_reset", 1'b0, 16'd0, 1'b0, 1'b1);

        // Basic scan: 0x8421 base 100 -> 115, 110, 105, 100
        next_cycle();
        in_valid = 1'b1; in_data = 16'h8421; in_base = 16'd100; out_ready = 1'b1;
        #1;
        check_main("basic_offer", 1'b0, 16'd0, 1'b0, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("basic_115", 1'b1, 16'd115, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("basic_110", 1'b1, 16'd110, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("basic_105", 1'b1, 16'd105, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("basic_100", 1'b1, 16'd100, 1'b1, 1'b1);
        next_cycle(); #1;
        check_main("basic_done", 1'b0, 16'd0, 1'b0, 1'b1);

        // Backpressure: 0x0003 base 0, out_ready low for 3 cycles
        in_valid = 1'b1; in_data = 16'h0003; in_base = 16'd0; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("bp_hold0", 1'b1, 16'd1, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("bp_hold1", 1'b1, 16'd1, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("bp_hold2", 1'b1, 16'd1, 1'b0, 1'b0);
        next_cycle();
        out_ready = 1'b1;
        #1;
        check_main("bp_idx1", 1'b1, 16'd1, 1'b0, 1'b0);
        next_cycle(); #1;
        check_main("bp_idx0", 1'b1, 16'd0, 1'b1, 1'b1);
        next_cycle(); #1;
        check_main("bp_done", 1'b0, 16'd0, 1'b0, 1'b1);

        // Back-to-back: 0x0001 base 0 then 0x8000 base 16
        in_valid = 1'b1; in_data = 16'h0001; in_base = 16'd0;
        next_cycle();
        in_data = 16'h8000; in_base = 16'd16;
        #1;
        check_main("b2b_0", 1'b1, 16'd0, 1'b1, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("b2b_31", 1'b1, 16'd31, 1'b1, 1'b1);
        next_cycle(); #1;
        check_main("b2b_done", 1'b0, 16'd0, 1'b0, 1'b1);

        // Zero word in IDLE
        in_valid = 1'b1; in_data = 16'h0000; in_base = 16'd5;
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("zero_idle", 1'b0, 16'd0, 1'b0, 1'b1);

        // Zero word on a last-bit cycle: 0x0004 base 10, then 0x0000
        next_cycle();
        in_valid = 1'b1; in_data = 16'h0004; in_base = 16'd10;
        next_cycle();
        in_data = 16'h0000; in_base = 16'd0;
        #1;
        check_main("zero_last_12", 1'b1, 16'd12, 1'b1, 1'b1);
        next_cycle();
        in_data = 16'h0002; in_base = 16'd0;
        #1;
        check_main("zero_last_idle", 1'b0, 16'd0, 1'b0, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("zero_last_next", 1'b1, 16'd1, 1'b1, 1'b1);
        next_cycle(); #1;
        check_main("zero_last_done", 1'b0, 16'd0, 1'b0, 1'b1);

        // Wrap: 0xFFFF at base 0xFFF8 -> 0x0007 down to 0xFFF8
        in_valid = 1'b1; in_data = 16'hFFFF; in_base = 16'hFFF8;
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            exp_idx = 16'hFFF8 + 16'(15 - k);
            check_main($sformatf("wrap_%0d", k), 1'b1, exp_idx, (k == 15), (k == 15));
            next_cycle();
        end
        #1;
        check_main("wrap_done", 1'b0, 16'd0, 1'b0, 1'b1);

        // Reset asserted mid-cycle during SCAN discards the word
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0003; in_base = 16'd40;
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_main("rst_mid_pre", 1'b1, 16'd41, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_main("rst_mid_on", 1'b0, 16'd0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_main("rst_mid_rel", 1'b0, 16'd0, 1'b0, 1'b1);
        next_cycle(); #1;
        check_main("rst_mid_after", 1'b0, 16'd0, 1'b0, 1'b1);

        // WIDTH_LOG=1: 2'b11 base 7 -> 8, 7
        in_valid1 = 1'b1; in_data1 = 2'b11; in_base1 = 16'd7;
        // WIDTH_LOG=6: bits 63 and 0 at base 1000 -> 1063, 1000
        in_valid6 = 1'b1; in_data6 = 64'h8000_0000_0000_0001; in_base6 = 16'd1000;
        next_cycle();
        in_valid1 = 1'b0; in_valid6 = 1'b0;
        #1;
        check("w1_first.idx",  64'(out_idx1),  64'd8);
        check("w1_first.last", 64'(out_last1), 64'd0);
        check("w6_first.idx",  64'(out_idx6),  64'd1063);
        check("w6_first.last", 64'(out_last6), 64'd0);
        next_cycle(); #1;
        check("w1_second.idx",  64'(out_idx1),  64'd7);
        check("w1_second.last", 64'(out_last1), 64'd1);
        check("w6_second.idx",  64'(out_idx6),  64'd1000);
        check("w6_second.last", 64'(out_last6), 64'd1);
        next_cycle(); #1;
        check("w1_done.valid", 64'(out_valid1), 64'd0);
        check("w6_done.valid", 64'(out_valid6), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
